alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_pkg.sv | 18 +
 rtl/result_fifo2.sv | 56 +++++
 rtl/alu_result_stage.sv | 113 +++++++++++
 tb/tb_alu_result_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: per-entry flag record and the
// shifter-select encodings.
package alu_result_stage_pkg;

   localparam logic SEL_LEFT  = 1'b0;
   localparam logic SEL_RIGHT = 1'b1;

   // Flag part of a stored entry; the result field is added per instance width.
   typedef struct packed {
      logic c;
      logic n;
      logic v;
      logic z;
   } flags_t;

   localparam int unsigned FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO (skid buffer) with wrapping 1-bit pointers and a registered
// occupancy count; full/empty come straight from state.
module result_fifo2 #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [1:0][Width-1:0] mem_q;
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q, count_d;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign rdata_o = mem_q[rd_ptr_q];

   // Guard here too so a careless caller cannot over/underflow the count.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects left/right shifter result, derives Z, buffers in a
// 2-entry FIFO, and tracks sticky C/V of popped entries plus an accept counter.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int unsigned bits  = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel,
   input  logic [bits-1:0]  sl_out,
   input  logic [bits-1:0]  sr_out,
   input  logic             sl_c,
   input  logic             sl_n,
   input  logic             sl_v,
   input  logic             sr_c,
   input  logic             sr_n,
   input  logic             sr_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [bits-1:0]  res,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_z,
   output logic             sticky_c,
   output logic             sticky_v,
   input  logic             sticky_clr,
   output logic [CNT_W-1:0] acc_cnt
);

   typedef struct packed {
      logic [bits-1:0] result;
      flags_t          flags;
   } entry_t;

   localparam int unsigned EntryW = $bits(entry_t);

   entry_t            in_entry, head;
   logic [EntryW-1:0] head_raw;
   logic              full, empty, push, pop;
   logic              sticky_c_q, sticky_v_q, sticky_c_d, sticky_v_d;
   logic [CNT_W-1:0]  acc_cnt_q;

   always_comb begin
      in_entry = '0;
      if (sel == SEL_RIGHT) begin
         in_entry.result  = sr_out;
         in_entry.flags.c = sr_c;
         in_entry.flags.n = sr_n;
         in_entry.flags.v = sr_v;
      end else begin
         in_entry.result  = sl_out;
         in_entry.flags.c = sl_c;
         in_entry.flags.n = sl_n;
         in_entry.flags.v = sl_v;
      end
      in_entry.flags.z = (in_entry.result == '0);
   end

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   result_fifo2 #(
      .Width (EntryW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_entry),
      .rdata_o (head_raw),
      .full_o  (full),
      .empty_o (empty)
   );

   assign head   = entry_t'(head_raw);
   assign res    = head.result;
   assign flag_c = head.flags.c;
   assign flag_n = head.flags.n;
   assign flag_v = head.flags.v;
   assign flag_z = head.flags.z;

   // Clear applies first so a flag popped in the clearing cycle survives.
   always_comb begin
      sticky_c_d = (sticky_clr ? 1'b0 : sticky_c_q) | (pop & head.flags.c);
      sticky_v_d = (sticky_clr ? 1'b0 : sticky_v_q) | (pop & head.flags.v);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_c_q <= 1'b0;
         sticky_v_q <= 1'b0;
         acc_cnt_q  <= '0;
      end else begin
         sticky_c_q <= sticky_c_d;
         sticky_v_q <= sticky_v_d;
         if (push) begin
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
         end
      end
   end

   assign sticky_c = sticky_c_q;
   assign sticky_v = sticky_v_q;
   assign acc_cnt  = acc_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

   logic       clk, rst_n;
   logic       in_valid, in_ready, sel, out_valid, out_ready, sticky_clr;
   logic [3:0] sl_out, sr_out, res;
   logic       sl_c, sl_n, sl_v, sr_c, sr_n, sr_v;
   logic       flag_c, flag_n, flag_v, flag_z, sticky_c, sticky_v;
   logic [7:0] acc_cnt;

   int checks   = 0;
   int failures = 0;

   alu_result_stage #(
      .bits  (4),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .sl_out     (sl_out),
      .sr_out     (sr_out),
      .sl_c       (sl_c),
      .sl_n       (sl_n),
      .sl_v       (sl_v),
      .sr_c       (sr_c),
      .sr_n       (sr_n),
      .sr_v       (sr_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .res        (res),
      .flag_c     (flag_c),
      .flag_n     (flag_n),
      .flag_v     (flag_v),
      .flag_z     (flag_z),
      .sticky_c   (sticky_c),
      .sticky_v   (sticky_v),
      .sticky_clr (sticky_clr),
      .acc_cnt    (acc_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
      sl_out = '0; sr_out = '0;
      sl_c = 0; sl_n = 0; sl_v = 0; sr_c = 0; sr_n = 0; sr_v = 0;

      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_res", res, 0);
      check("rst_flags", {flag_c, flag_n, flag_v, flag_z}, 0);
      check("rst_sticky", {sticky_c, sticky_v}, 0);
      check("rst_acc", acc_cnt, 0);
      #10 rst_n = 1'b1;

      // Single pass, pushed on first edge after reset release
      in_valid = 1; sel = 0; sl_out = 4'b1000; sl_c = 1; sl_n = 1; sl_v = 0; out_ready = 1;
      sr_out = 4'b0001;
      tick();
      in_valid = 0;
      check("pass_valid", out_valid, 1);
      check("pass_res", res, 8);
      check("pass_cnvz", {flag_c, flag_n, flag_v, flag_z}, 4'b1100);
      check("pass_acc", acc_cnt, 1);
      tick();
      check("pass_drained", out_valid, 0);
      check("pass_sticky_c", sticky_c, 1);

      // Zero result from right shifter; left side nonzero to prove sel matters
      in_valid = 1; sel = 1; sr_out = 0; sr_c = 0; sr_n = 0; sr_v = 0;
      sl_out = 4'b0101; sl_c = 1; sl_n = 1;
      tick();
      in_valid = 0;
      check("zero_res", res, 0);
      check("zero_z", flag_z, 1);
      check("zero_n", flag_n, 0);
      check("zero_c", flag_c, 0);
      check("zero_acc", acc_cnt, 2);
      tick();
      check("sticky_hold_c1_c0", sticky_c, 1);

      // Clear while popping C=0 -> 0; clear while popping C=1,V=1 -> 1
      in_valid = 1; sel = 0; sl_out = 1; sl_c = 0; sl_n = 0; sl_v = 0;
      tick();
      in_valid = 0; sticky_clr = 1;
      tick();
      sticky_clr = 0;
      check("clr_pop_c0", sticky_c, 0);
      check("clr_pop_v0", sticky_v, 0);
      in_valid = 1; sl_out = 2; sl_c = 1; sl_v = 1;
      tick();
      in_valid = 0; sticky_clr = 1;
      tick();
      sticky_clr = 0;
      check("clr_pop_c1", sticky_c, 1);
      check("clr_pop_v1", sticky_v, 1);

      // Re-reset between edges
      rst_n = 0;
      #1;
      check("rerst_acc", acc_cnt, 0);
      check("rerst_sticky", {sticky_c, sticky_v}, 0);
      rst_n = 1;

      // Backpressure: A=3, B=5 stored, C=7 refused
      out_ready = 0; in_valid = 1; sel = 0; sl_c = 0; sl_n = 0; sl_v = 0; sl_out = 3;
      tick();
      check("bp_ready_occ1", in_ready, 1);
      sl_out = 5;
      tick();
      check("bp_ready_full", in_ready, 0);
      check("bp_head_a", res, 3);
      sl_out = 7;
      tick();
      check("bp_acc_no_c", acc_cnt, 2);
      check("bp_head_hold", res, 3);
      in_valid = 0; out_ready = 1;
      tick();
      check("bp_second", res, 5);
      check("bp_ready_after_pop", in_ready, 1);
      tick();
      check("bp_empty", out_valid, 0);
      check("bp_acc", acc_cnt, 2);

      // Simultaneous push/pop at occupancy 1; pointers wrap
      in_valid = 1; sl_out = 1;
      tick();
      check("flow_res_1", res, 1);
      for (int v = 2; v <= 4; v++) begin
         sl_out = 4'(v);
         tick();
         check("flow_valid", out_valid, 1);
         check("flow_res", res, 32'(v));
         check("flow_occ1_ready", in_ready, 1);
      end
      in_valid = 0;
      tick();
      check("flow_drained", out_valid, 0);
      check("flow_acc", acc_cnt, 6);

      // Reset with two entries held, no clock edge
      out_ready = 0; in_valid = 1; sl_out = 9;
      tick();
      sl_out = 10;
      tick();
      in_valid = 0;
      check("hold2_full", in_ready, 0);
      #2 rst_n = 0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_in_ready", in_ready, 1);
      check("async_acc", acc_cnt, 0);
      check("async_res", res, 0);
      #1 rst_n = 1;
      in_valid = 1; sl_out = 6;
      tick();
      in_valid = 0;
      check("first_push_valid", out_valid, 1);
      check("first_push_res", res, 6);
      check("first_push_acc", acc_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
